// File: rtl/fp_add_pipe.sv
// fp_add_pipe -- three-stage pipelined floating-point adder.
//
// Operands and result are packed {sign, exp[EXP_W-1:0], mant[MANT_W-1:0]}.
// The stages are:
//   S1 unpack, classify specials, swap so the larger magnitude comes first,
//      align the smaller significand (guard/round/sticky kept)
//   S2 add/subtract magnitudes, leading-one detect
//   S3 normalise, round, detect under/overflow, pack
//
// Denormal inputs are treated as signed zero, and underflowing results
// flush to +0. NaN/Inf results set answer_status_o.
//
// Build option:
//   FP_ADD_PIPE_RNE_EN  defined   : round to nearest, ties to even
//                       undefined : truncate (round toward zero)
//
// Ports:
//   clk_i           clock; all state changes on the rising edge
//   rst_i           synchronous active-high reset
//   vld_i / rdy_o   input handshake; a_i and b_i are taken when both are high
//   a_i, b_i        operands
//   vld_o / rdy_i   output handshake; the result is taken when both are high
//   answer_o        sum
//   answer_status_o 0 = ordinary result, 1 = NaN or Inf
//
// Flow control: the whole pipe advances when rdy_i || !vld_o. Stage valids
// shift along with the data, so bubbles stay bubbles. Because of this,
// results can never be reordered, dropped or duplicated.
module fp_add_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      vld_i,
  output logic                      rdy_o,
  input  logic [EXP_W+MANT_W:0]     a_i,
  input  logic [EXP_W+MANT_W:0]     b_i,
  output logic                      vld_o,
  input  logic                      rdy_i,
  output logic [EXP_W+MANT_W:0]     answer_o,
  output logic                      answer_status_o
);

  localparam int W      = 1 + EXP_W + MANT_W;
  localparam int STAGES = 3;
  // significand: hidden bit, fraction, guard, round, sticky
  localparam int SIG_W  = MANT_W + 4;
  // one extra bit for the carry out of the add
  localparam int SUM_W  = SIG_W + 1;
  localparam int LZ_W   = $clog2(SUM_W + 1);
  // signed working exponent, wide enough for exp+1 and exp-SUM_W
  localparam int EXT_W  = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

  typedef struct packed {
    logic             sign;     // sign of the larger operand
    logic [EXP_W-1:0] exp;      // exponent of the larger operand
    logic [SIG_W-1:0] sig_l;
    logic [SIG_W-1:0] sig_s;    // already aligned to sig_l
    logic             sub;      // operand signs differ
    logic             zsign;    // sign of a zero sum (only -0 + -0 gives -0)
    logic             spec;     // NaN/Inf result, bypasses the datapath
    logic [W-1:0]     spec_val;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SUM_W-1:0] sum;
    logic [LZ_W-1:0]  lz;       // leading zeros of sum, SUM_W when sum is 0
    logic             zsign;
    logic             spec;
    logic [W-1:0]     spec_val;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            en;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [W-1:0]    ans_d, ans_q;
  logic            stat_d, stat_q;

  assign en    = rdy_i | ~vld_pipe[STAGES];
  assign rdy_o = en;

  // ------------------------------------------------------------ S1
  logic                   sa, sb;
  logic [EXP_W-1:0]       ea, eb, ea_eff, eb_eff;
  logic [MANT_W-1:0]      ma, mb;
  logic                   a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic [EXP_W+MANT_W-1:0] mag_a, mag_b;
  logic [SIG_W-1:0]       sig_a, sig_b, sig_l, sig_s_raw, sig_s_al;
  logic [EXP_W-1:0]       exp_l, exp_s, diff;
  logic                   a_big;

  assign {sa, ea, ma} = a_i;
  assign {sb, eb, mb} = b_i;

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);

  // Denormals collapse to zero before the magnitude compare, so the
  // "larger" operand is always the one that survives alignment.
  assign ea_eff = a_zero ? '0 : ea;
  assign eb_eff = b_zero ? '0 : eb;
  assign mag_a  = a_zero ? '0 : {ea, ma};
  assign mag_b  = b_zero ? '0 : {eb, mb};
  assign sig_a  = a_zero ? '0 : {1'b1, ma, 3'b000};
  assign sig_b  = b_zero ? '0 : {1'b1, mb, 3'b000};

  assign a_big     = (mag_a >= mag_b);
  assign exp_l     = a_big ? ea_eff : eb_eff;
  assign exp_s     = a_big ? eb_eff : ea_eff;
  assign sig_l     = a_big ? sig_a  : sig_b;
  assign sig_s_raw = a_big ? sig_b  : sig_a;
  assign diff      = exp_l - exp_s;

  // Right shift with sticky. The sticky bit is needed in both rounding
  // modes: when subtracting, it keeps the difference off an exact LSB
  // boundary, so truncation still lands on the correct side.
  always_comb begin
    logic [SIG_W-1:0] shifted;
    logic             lost;
    shifted  = '0;
    lost     = 1'b0;
    sig_s_al = '0;
    if (int'(diff) >= SIG_W - 1) begin
      sig_s_al[0] = |sig_s_raw;
    end else begin
      shifted  = sig_s_raw >> diff;
      lost     = |(sig_s_raw & ~({SIG_W{1'b1}} << diff));
      sig_s_al = {shifted[SIG_W-1:1], shifted[0] | lost};
    end
  end

  always_comb begin
    s1_d       = '0;
    s1_d.sign  = a_big ? sa : sb;
    s1_d.exp   = exp_l;
    s1_d.sig_l = sig_l;
    s1_d.sig_s = sig_s_al;
    s1_d.sub   = sa ^ sb;
    s1_d.zsign = sa & sb;
    if (a_nan || b_nan) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = QNAN;
    end else if (a_inf && b_inf) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = (sa == sb) ? a_i : QNAN;
    end else if (a_inf) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = a_i;
    end else if (b_inf) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = b_i;
    end
  end

  // ------------------------------------------------------------ S2
  logic [SUM_W-1:0] sum;
  logic [LZ_W-1:0]  lz;

  // sig_l >= sig_s always, so the subtraction never goes negative.
  assign sum = s1_q.sub ? ({1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_s})
                        : ({1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s});

  always_comb begin
    lz = LZ_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++)
      if (sum[i]) lz = LZ_W'(SUM_W - 1 - i);
  end

  always_comb begin
    s2_d          = '0;
    s2_d.sign     = s1_q.sign;
    s2_d.exp      = s1_q.exp;
    s2_d.sum      = sum;
    s2_d.lz       = lz;
    s2_d.zsign    = s1_q.zsign;
    s2_d.spec     = s1_q.spec;
    s2_d.spec_val = s1_q.spec_val;
  end

  // ------------------------------------------------------------ S3
  // Shifting by lz puts the leading one at the top bit. This covers the
  // carry case too (lz=0). The exponent therefore moves by 1-lz.
  logic [SUM_W-1:0]  norm;
  logic [MANT_W-1:0] mant, mant_r;
  logic [EXT_W-1:0]  exp_n, exp_r;
  logic              unused_bits;

  assign norm  = s2_q.sum << s2_q.lz;
  assign mant  = norm[SUM_W-2 -: MANT_W];
  assign exp_n = EXT_W'(s2_q.exp) + EXT_W'(1) - EXT_W'(s2_q.lz);

`ifdef FP_ADD_PIPE_RNE_EN
  logic g_bit, r_bit, s_bit, rnd_up, rnd_cy;
  assign g_bit  = norm[3];
  assign r_bit  = norm[2];
  assign s_bit  = |norm[1:0];
  assign rnd_up = g_bit & (r_bit | s_bit | mant[0]);
  // A carry out of the fraction leaves mant_r at zero, which is the
  // correct 1.0 x 2^(exp+1).
  assign {rnd_cy, mant_r} = {1'b0, mant} + {{MANT_W{1'b0}}, rnd_up};
  assign exp_r  = exp_n + EXT_W'(rnd_cy);
  assign unused_bits = norm[SUM_W-1];
`else
  assign mant_r = mant;
  assign exp_r  = exp_n;
  assign unused_bits = ^{norm[SUM_W-1], norm[3:0]};
`endif

  always_comb begin
    ans_d  = '0;
    stat_d = 1'b0;
    if (s2_q.spec) begin
      ans_d  = s2_q.spec_val;
      stat_d = 1'b1;
    end else if (s2_q.sum == '0) begin
      ans_d = {s2_q.zsign, {(W-1){1'b0}}};
    end else if (exp_n[EXT_W-1] || (exp_n == '0)) begin
      ans_d = '0;  // underflow flushes to +0
    end else if (exp_r >= EXT_W'(EXP_ONES)) begin
      ans_d  = {s2_q.sign, EXP_ONES, {MANT_W{1'b0}}};
      stat_d = 1'b1;
    end else begin
      ans_d = {s2_q.sign, exp_r[EXP_W-1:0], mant_r};
    end
  end

  // ------------------------------------------------------------ registers
  // Data registers load only for valid entries. This keeps answer_o at
  // zero after reset until the first real result arrives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      ans_q    <= '0;
      stat_q   <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], vld_i};
      if (vld_i)       s1_q <= s1_d;
      if (vld_pipe[1]) s2_q <= s2_d;
      if (vld_pipe[2]) begin
        ans_q  <= ans_d;
        stat_q <= stat_d;
      end
    end
  end

  assign vld_o           = vld_pipe[STAGES];
  assign answer_o        = ans_q;
  assign answer_status_o = stat_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Testbench for fp_add_pipe (EXP_W=8, MANT_W=23).
// The bench contains directed vectors, hand-written stall and reset
// sequences, and random traffic with random handshakes. The random results
// are scored against an exact wide-integer model.
module tb_fp_add_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        vld_i;
  logic        rdy_o;
  logic [31:0] a_i, b_i;
  logic        vld_o;
  logic        rdy_i;
  logic [31:0] answer_o;
  logic        answer_status_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fp_add_pipe #(.EXP_W(8), .MANT_W(23)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .vld_i           (vld_i),
    .rdy_o           (rdy_o),
    .a_i             (a_i),
    .b_i             (b_i),
    .vld_o           (vld_o),
    .rdy_i           (rdy_i),
    .answer_o        (answer_o),
    .answer_status_o (answer_status_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Exact reference: both operands become integers in units of 2^-149, so
  // the sum has no error. The result is then rounded from the full remainder.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic st);
    logic        sa, sb, sr;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb, mant;
    logic [319:0] va, vb, mag, tmp;
    int p, e;
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    r = '0; st = 1'b0;
    if ((ea == 8'hFF && ma != 0) || (eb == 8'hFF && mb != 0)) begin
      r = 32'h7FC00000; st = 1'b1; return;
    end
    if (ea == 8'hFF && eb == 8'hFF) begin
      r = (sa == sb) ? a : 32'h7FC00000; st = 1'b1; return;
    end
    if (ea == 8'hFF) begin r = a; st = 1'b1; return; end
    if (eb == 8'hFF) begin r = b; st = 1'b1; return; end
    va = (ea == 0) ? '0 : (320'({1'b1, ma}) << (ea - 8'd1));
    vb = (eb == 0) ? '0 : (320'({1'b1, mb}) << (eb - 8'd1));
    if (sa == sb)      begin mag = va + vb; sr = sa; end
    else if (va >= vb) begin mag = va - vb; sr = sa; end
    else               begin mag = vb - va; sr = sb; end
    if (mag == 0) begin r = {sa & sb, 31'b0}; return; end
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) begin r = '0; return; end
    tmp  = mag >> (p - 23);
    mant = tmp[22:0];
`ifdef FP_ADD_PIPE_RNE_EN
    if (p > 23) begin
      logic [319:0] rem, half;
      rem  = mag & ((320'(1) << (p - 23)) - 320'(1));
      half = 320'(1) << (p - 24);
      if (rem > half || (rem == half && mant[0])) begin
        mant = mant + 23'd1;
        if (mant == 0) e = e + 1;
      end
    end
`endif
    if (e >= 255) begin r = {sr, 8'hFF, 23'b0}; st = 1'b1; return; end
    r = {sr, 8'(e), mant};
  endfunction

  function automatic logic [31:0] rnd_op(input logic [31:0] other);
    logic [31:0] sp [6];
    logic [7:0]  ex;
    sp[0] = 32'h00000000; sp[1] = 32'h80000000; sp[2] = 32'h7F800000;
    sp[3] = 32'hFF800000; sp[4] = 32'h7FC00001; sp[5] = 32'h00000123;
    case ($urandom_range(0, 9))
      0: return sp[$urandom_range(0, 5)];
      1, 2: begin
        ex = other[30:23] + 8'($urandom_range(0, 2)) - 8'd1;
        return {1'($urandom_range(0, 1)), ex, 23'($urandom())};
      end
      3: return {~other[31], other[30:0]};
      default: return $urandom();
    endcase
  endfunction

  // Single transaction with rdy_i held high; lat counts clocks to vld_o.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic st, output int lat);
    @(negedge clk_i);
    rdy_i = 1'b1; vld_i = 1'b1; a_i = a; b_i = b;
    @(negedge clk_i);
    vld_i = 1'b0; lat = 1;
    while (!vld_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    r = answer_o; st = answer_status_o;
  endtask

  typedef struct {
    logic [31:0] a, b, exp;
    logic        st;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [31:0] r, e5, e17, e18;
    logic        st, s18;
    int          lat;

`ifdef FP_ADD_PIPE_RNE_EN
    e5 = 32'h3F800002; e17 = 32'h3F800000; e18 = 32'h7F800000; s18 = 1'b1;
`else
    e5 = 32'h3F800001; e17 = 32'h3F7FFFFF; e18 = 32'h7F7FFFFF; s18 = 1'b0;
`endif
    vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0});
    vecs.push_back('{32'h3FC00000, 32'hBFC00000, 32'h00000000, 1'b0});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1});
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1});
    vecs.push_back('{32'h3F800001, 32'h33800000, e5,           1'b0});
    vecs.push_back('{32'h80000000, 32'h80000000, 32'h80000000, 1'b0});
    vecs.push_back('{32'h00000000, 32'h80000000, 32'h00000000, 1'b0});
    vecs.push_back('{32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1'b1});
    vecs.push_back('{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b1});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7F800000, 1'b1});
    vecs.push_back('{32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0});
    vecs.push_back('{32'h40400000, 32'hC0000000, 32'h3F800000, 1'b0});
    vecs.push_back('{32'h3F800000, 32'hBF7FFFFF, 32'h33800000, 1'b0});
    vecs.push_back('{32'h00800000, 32'h80800001, 32'h00000000, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h00000000, 32'h3F800000, 1'b0});
    vecs.push_back('{32'hC0000000, 32'hC0000000, 32'hC0800000, 1'b0});
    vecs.push_back('{32'h3F800000, 32'hB3000000, e17,          1'b0});
    vecs.push_back('{32'h7F7FFFFF, 32'h73000000, e18,          s18});

    // ---- reset
    rst_i = 1'b1; vld_i = 1'b0; rdy_i = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_vld_o", 64'(vld_o), 64'd0);
    check("reset_answer", 64'(answer_o), 64'd0);
    check("reset_status", 64'(answer_status_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_rdy_o", 64'(rdy_o), 64'd1);

    // ---- directed vectors, one at a time
    foreach (vecs[i]) begin
      run_one(vecs[i].a, vecs[i].b, r, st, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      check($sformatf("vec%0d_result", i), 64'({st, r}), 64'({vecs[i].st, vecs[i].exp}));
    end
    @(negedge clk_i);

    // ---- four back-to-back inputs, rdy_i low for the first five cycles
    begin
      logic [31:0] oa [4], ob [4], oe [4];
      logic [31:0] got [$];
      int idx = 0;
      oa[0] = 32'h3F800000; ob[0] = 32'h3F800000; oe[0] = 32'h40000000;
      oa[1] = 32'h40000000; ob[1] = 32'h40000000; oe[1] = 32'h40800000;
      oa[2] = 32'h40400000; ob[2] = 32'h40400000; oe[2] = 32'h40C00000;
      oa[3] = 32'h3F800000; ob[3] = 32'h40000000; oe[3] = 32'h40400000;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk_i);
        rdy_i = (c >= 5);
        vld_i = (idx < 4);
        a_i = oa[idx % 4]; b_i = ob[idx % 4];
        #1;
        if (c < 4) check($sformatf("stall_rdy_o_c%0d", c), 64'(rdy_o), 64'(c < 3));
        if (vld_o && rdy_i) got.push_back(answer_o);
        if (vld_i && rdy_o) idx++;
      end
      vld_i = 1'b0;
      check("stall_count", 64'(got.size()), 64'd4);
      for (int k = 0; k < 4; k++)
        if (k < got.size()) check($sformatf("stall_out%0d", k), 64'(got[k]), 64'(oe[k]));
    end

    // ---- reset with two operations in flight
    begin
      int nvld = 0;
      @(negedge clk_i);
      rdy_i = 1'b0; vld_i = 1'b1; a_i = 32'h3F800000; b_i = 32'h3F800000;
      @(negedge clk_i);
      a_i = 32'h40000000; b_i = 32'h40000000;
      @(negedge clk_i);
      vld_i = 1'b0; rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("rst_flight_vld_o", 64'(vld_o), 64'd0);
      check("rst_flight_answer", 64'(answer_o), 64'd0);
      check("rst_flight_status", 64'(answer_status_o), 64'd0);
      check("rst_flight_rdy_o", 64'(rdy_o), 64'd1);
      rdy_i = 1'b1;
      repeat (6) begin
        @(negedge clk_i);
        if (vld_o) nvld++;
      end
      check("rst_flight_no_vld", 64'(nvld), 64'd0);
      run_one(32'h40400000, 32'h3F800000, r, st, lat);
      check("rst_after_latency", 64'(lat), 64'd3);
      check("rst_after_result", 64'({st, r}), 64'({1'b0, 32'h40800000}));
    end

    // ---- random traffic with random handshakes
    begin
      localparam int N = 400;
      logic [32:0] q [$];
      logic [31:0] ca, cb, rr;
      logic        rs, have;
      int sent = 0, recv = 0, spurious = 0, cyc = 0;
      have = 1'b0; ca = '0; cb = '0;
      while (recv < N && cyc < 20000) begin
        @(negedge clk_i);
        if (!have && sent < N && $urandom_range(0, 3) != 0) begin
          ca = rnd_op($urandom());
          cb = rnd_op(ca);
          have = 1'b1;
        end
        vld_i = have; a_i = ca; b_i = cb;
        rdy_i = ($urandom_range(0, 3) != 0);
        #1;
        if (vld_o && rdy_i) begin
          if (q.size() == 0) spurious++;
          else check($sformatf("rand%0d", recv), 64'({answer_status_o, answer_o}), 64'(q.pop_front()));
          recv++;
        end
        if (vld_i && rdy_o) begin
          ref_add(ca, cb, rr, rs);
          q.push_back({rs, rr});
          have = 1'b0;
          sent++;
        end
        cyc++;
      end
      vld_i = 1'b0;
      check("rand_received", 64'(recv), 64'(N));
      check("rand_spurious", 64'(spurious), 64'd0);
      check("rand_leftover", 64'(q.size()), 64'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
